// File: rtl/execute_rtl.sv
// Execute stage: single-cycle ALU plus optional iterative unsigned multiply/divide.
// Define EXEC_MULDIV_EN to include the MUL/DIV FSM and the MUL/MULHU/DIVU/REMU funcs.
module execute_rtl (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [6:0]  opcode,
  input  logic [3:0]  func,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm,
  input  logic        hata_in,
  output logic        stall,
  output logic        we,
  output logic [31:0] rd_data,
  output logic        hata,
  output logic [31:0] retired
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  logic        is_r, is_i, is_lui;
  logic        md_func, r_func_ok, illegal, single_ok, in_idle;
  logic [3:0]  alu_func;
  logic [31:0] alu_b, single_result;
  logic [4:0]  shamt;

  assign is_r   = (opcode == OP_R);
  assign is_i   = (opcode == OP_I);
  assign is_lui = (opcode == OP_LUI);

`ifdef EXEC_MULDIV_EN
  assign md_func = (func == 4'b1001) | (func == 4'b1010) | (func == 4'b1011) | (func == 4'b1100);
`else
  assign md_func = 1'b0;
`endif

  // I-type ignores func[3] except to select SRA over SRL.
  assign alu_func = is_r ? func : {func[3] & (func[2:0] == 3'b101), func[2:0]};
  assign alu_b    = is_r ? rs2_data : imm;
  assign shamt    = alu_b[4:0];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    r_func_ok = md_func;
    case (func)
      4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
      4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111: r_func_ok = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    single_result = 32'd0;
    if (is_lui) begin
      single_result = imm;
    end else begin
      case (alu_func)
        4'b0000: single_result = rs1_data + alu_b;
        4'b1000: single_result = rs1_data - alu_b;
        4'b0001: single_result = rs1_data << shamt;
        4'b0010: single_result = {31'd0, $signed(rs1_data) < $signed(alu_b)};
        4'b0011: single_result = {31'd0, rs1_data < alu_b};
        4'b0100: single_result = rs1_data ^ alu_b;
        4'b0101: single_result = rs1_data >> shamt;
        4'b1101: single_result = 32'($signed(rs1_data) >>> shamt);
        4'b0110: single_result = rs1_data | alu_b;
        4'b0111: single_result = rs1_data & alu_b;
        default: single_result = 32'd0;
      endcase
    end
  end

  assign illegal   = valid & (hata_in | ~(is_i | is_lui | (is_r & r_func_ok)));
  assign single_ok = valid & ~illegal & ~(is_r & md_func);

`ifdef EXEC_MULDIV_EN
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state, next_state;
  logic [4:0]  count;
  logic [31:0] lat_a, lat_b, acc_hi, acc_lo, md_result;
  logic [3:0]  lat_func;
  logic        start_md, start_mul, div_ok;
  logic [32:0] mul_sum, div_trial;

  assign start_md  = valid & ~hata_in & is_r & md_func;
  assign start_mul = (func == 4'b1001) | (func == 4'b1010);
  assign in_idle   = (state == IDLE);

  // acc_hi:acc_lo is the running product for MUL and remainder:quotient for DIV.
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, lat_a} : 33'd0);
  assign div_trial = {acc_hi, acc_lo[31]};
  assign div_ok    = (div_trial >= {1'b0, lat_b});
  assign md_result = ((lat_func == 4'b1001) || (lat_func == 4'b1011)) ? acc_lo : acc_hi;

  always_comb begin
    next_state = state;
    stall      = 1'b0;
    we         = 1'b0;
    rd_data    = 32'd0;
    case (state)
      IDLE: begin
        if (start_md) begin
          stall      = 1'b1;
          next_state = start_mul ? MUL : DIV;
        end else if (single_ok) begin
          we      = 1'b1;
          rd_data = single_result;
        end
      end
      MUL, DIV: begin
        stall = 1'b1;
        if (count == 5'd31) next_state = DONE;
      end
      DONE: begin
        we         = 1'b1;
        rd_data    = md_result;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    // Reset low must silence outputs immediately, even during the accept cycle.
    if (!reset) begin
      stall   = 1'b0;
      we      = 1'b0;
      rd_data = 32'd0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= 5'd0;
      lat_a    <= 32'd0;
      lat_b    <= 32'd0;
      lat_func <= 4'd0;
      acc_hi   <= 32'd0;
      acc_lo   <= 32'd0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (start_md) begin
            lat_a    <= rs1_data;
            lat_b    <= rs2_data;
            lat_func <= func;
            count    <= 5'd0;
            acc_hi   <= 32'd0;
            acc_lo   <= start_mul ? rs2_data : rs1_data;
          end
        end
        MUL: begin
          {acc_hi, acc_lo} <= {mul_sum, acc_lo[31:1]};
          count            <= count + 5'd1;
        end
        DIV: begin
          acc_hi <= div_ok ? (div_trial[31:0] - lat_b) : div_trial[31:0];
          acc_lo <= {acc_lo[30:0], div_ok};
          count  <= count + 5'd1;
        end
        default: ;
      endcase
    end
  end
`else
  assign in_idle = 1'b1;
  assign stall   = 1'b0;
  assign we      = reset & single_ok;
  assign rd_data = we ? single_result : 32'd0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hata    <= 1'b0;
      retired <= 32'd0;
    end else begin
      if (in_idle && illegal) hata <= 1'b1;
      if (we) retired <= retired + 32'd1;
    end
  end

endmodule

// File: tb/tb_execute_rtl.sv
// Directed self-checking bench for execute_rtl; MUL/DIV vectors run when EXEC_MULDIV_EN is defined,
// otherwise those funcs are checked as illegal.
module tb_execute_rtl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid = 1'b0;
  logic [6:0]  opcode = 7'd0;
  logic [3:0]  func = 4'd0;
  logic [31:0] rs1_data = 32'd0;
  logic [31:0] rs2_data = 32'd0;
  logic [31:0] imm = 32'd0;
  logic        hata_in = 1'b0;
  logic        stall, we, hata;
  logic [31:0] rd_data, retired;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_retired = 32'd0;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  execute_rtl dut (
    .clk      (clk),
    .reset    (reset),
    .valid    (valid),
    .opcode   (opcode),
    .func     (func),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .imm      (imm),
    .hata_in  (hata_in),
    .stall    (stall),
    .we       (we),
    .rd_data  (rd_data),
    .hata     (hata),
    .retired  (retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic issue(input string tag, input logic [6:0] op, input logic [3:0] fn,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                       input logic [31:0] exp);
    opcode = op; func = fn; rs1_data = a; rs2_data = b; imm = im; hata_in = 1'b0; valid = 1'b1;
    @(negedge clk);
    check({tag, "_we"}, {31'd0, we}, 32'd1);
    check({tag, "_rd"}, rd_data, exp);
    @(posedge clk); #1;
    valid = 1'b0;
    exp_retired++;
  endtask

  task automatic expect_illegal(input string tag, input logic [6:0] op, input logic [3:0] fn,
                                input logic hin);
    opcode = op; func = fn; rs1_data = 32'd1; rs2_data = 32'd2; imm = 32'd3; hata_in = hin; valid = 1'b1;
    @(negedge clk);
    check({tag, "_we"}, {31'd0, we}, 32'd0);
    check({tag, "_rd"}, rd_data, 32'd0);
    check({tag, "_stall"}, {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    valid = 1'b0; hata_in = 1'b0;
    check({tag, "_hata"}, {31'd0, hata}, 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    check("reset_hata", {31'd0, hata}, 32'd0);
    check("reset_retired", retired, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_retired = 32'd0;
  endtask

`ifdef EXEC_MULDIV_EN
  task automatic muldiv(input string tag, input logic [3:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    opcode = OP_R; func = fn; rs1_data = a; rs2_data = b; hata_in = 1'b0; valid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (i == 0) check({tag, "_accept_we"}, {31'd0, we}, 32'd0);
      if (stall) begin
        n++;
      end else begin
        check({tag, "_we"}, {31'd0, we}, 32'd1);
        check({tag, "_rd"}, rd_data, exp);
        done = 1'b1;
      end
      @(posedge clk); #1;
      // Inputs outside IDLE must not affect the result.
      valid = 1'b0; rs1_data = 32'hDEAD_BEEF; rs2_data = 32'h1234_5678; func = 4'b0000;
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_stall_cycles"}, n, 32'd33);
    exp_retired++;
  endtask
`endif

  initial begin
    // Reset low with inputs toggling: all outputs stay 0.
    for (int i = 0; i < 4; i++) begin
      valid = i[0]; opcode = OP_R; func = 4'b0000; rs1_data = 32'(i + 1); rs2_data = 32'd9;
      @(negedge clk);
      check("rst_we", {31'd0, we}, 32'd0);
      check("rst_rd", rd_data, 32'd0);
      check("rst_stall", {31'd0, stall}, 32'd0);
      check("rst_hata", {31'd0, hata}, 32'd0);
      check("rst_retired", retired, 32'd0);
    end
    valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;

    issue("add", OP_R, 4'b0000, 32'd5, 32'd7, 32'd0, 32'd12);
    check("retired_after_add", retired, 32'd1);
    @(negedge clk);
    check("idle_we", {31'd0, we}, 32'd0);
    check("idle_rd", rd_data, 32'd0);
    @(posedge clk); #1;

    issue("i_sra", OP_I, 4'b1101, 32'h8000_0000, 32'd0, 32'd4, 32'hF800_0000);
    issue("i_f1000_add", OP_I, 4'b1000, 32'd3, 32'd99, 32'd2, 32'd5);
    issue("i_srl", OP_I, 4'b0101, 32'h8000_0000, 32'd0, 32'd4, 32'h0800_0000);
    issue("sub_wrap", OP_R, 4'b1000, 32'd5, 32'd7, 32'd0, 32'hFFFF_FFFE);
    issue("sll_shamt5", OP_R, 4'b0001, 32'd1, 32'h0000_003F, 32'd0, 32'h8000_0000);
    issue("slt", OP_R, 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1);
    issue("sltu", OP_R, 4'b0011, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
    issue("r_sra", OP_R, 4'b1101, 32'hF000_0000, 32'd8, 32'd0, 32'hFFF0_0000);
    issue("xor", OP_R, 4'b0100, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'd0, 32'hF0F0_F0F0);
    issue("or", OP_R, 4'b0110, 32'hFF00_0000, 32'h0000_00FF, 32'd0, 32'hFF00_00FF);
    issue("and", OP_R, 4'b0111, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'd0, 32'h0F00_0F00);
    issue("lui", OP_LUI, 4'b0000, 32'd1, 32'd2, 32'hABCD_E000, 32'hABCD_E000);
    check("retired_count", retired, exp_retired);

`ifdef EXEC_MULDIV_EN
    muldiv("mul", 4'b1001, 32'h0001_0000, 32'h0001_0000, 32'd0);
    muldiv("mulhu", 4'b1010, 32'h0001_0000, 32'h0001_0000, 32'd1);
    muldiv("mulhu_max", 4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    muldiv("mul_max", 4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
    muldiv("divu", 4'b1011, 32'd100, 32'd7, 32'd14);
    muldiv("remu", 4'b1100, 32'd100, 32'd7, 32'd2);
    muldiv("divu_zero", 4'b1011, 32'd12345, 32'd0, 32'hFFFF_FFFF);
    muldiv("remu_zero", 4'b1100, 32'd9, 32'd0, 32'd9);
    check("retired_muldiv", retired, exp_retired);

    // Reset pulse at iteration 10 of a DIVU aborts with no write.
    opcode = OP_R; func = 4'b1011; rs1_data = 32'd100; rs2_data = 32'd7; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check("abort_stall_before", {31'd0, stall}, 32'd1);
    reset = 1'b0;
    #1;
    check("abort_stall", {31'd0, stall}, 32'd0);
    check("abort_we", {31'd0, we}, 32'd0);
    check("abort_retired", retired, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_retired = 32'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_abort_we", {31'd0, we}, 32'd0);
      check("post_abort_stall", {31'd0, stall}, 32'd0);
    end
    @(posedge clk); #1;
    issue("add_after_abort", OP_R, 4'b0000, 32'd20, 32'd22, 32'd0, 32'd42);
    check("retired_after_abort", retired, 32'd1);
`else
    expect_illegal("mul_disabled", OP_R, 4'b1001, 1'b0);
    do_reset();
    expect_illegal("remu_disabled", OP_R, 4'b1100, 1'b0);
    do_reset();
`endif

    // Sticky illegal-instruction flag.
    expect_illegal("bad_opcode", OP_BR, 4'b0000, 1'b0);
    issue("add_while_hata", OP_R, 4'b0000, 32'd1, 32'd1, 32'd0, 32'd2);
    check("hata_sticky", {31'd0, hata}, 32'd1);
    expect_illegal("bad_rfunc", OP_R, 4'b1111, 1'b0);
    do_reset();
    expect_illegal("hata_in", OP_R, 4'b0000, 1'b1);
    issue("add_after_hata_in", OP_I, 4'b0000, 32'd10, 32'd0, 32'hFFFF_FFFF, 32'd9);
    check("hata_sticky2", {31'd0, hata}, 32'd1);
    check("retired_final", retired, exp_retired);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
